// File: rtl/wishbone_arbiter_pkg.sv
// Shared LC-3b types used by the wishbone arbiter: arbiter state, grant select
// and the bus widths of the 128-bit memory port.
package lc3b_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY0,
        ARB_BUSY1
    } lc3b_arb_state;

    typedef logic lc3b_arb_sel;

    localparam int WB_ADR_W = 16;
    localparam int WB_SEL_W = 16;
    localparam int WB_DAT_W = 128;

endpackage

// File: rtl/wishbone_arbiter_if.sv
// Classic wishbone bundle for the 128-bit memory port. The master modport is
// the side that starts cycles; the slave modport is the side that acknowledges.
interface wishbone;
    import lc3b_types::*;

    logic                CYC;
    logic                STB;
    logic                WE;
    logic [WB_SEL_W-1:0] SEL;
    logic [WB_ADR_W-1:0] ADR;
    logic [WB_DAT_W-1:0] DAT_M;
    logic [WB_DAT_W-1:0] DAT_S;
    logic                ACK;

    modport master (
        output CYC, STB, WE, SEL, ADR, DAT_M,
        input  DAT_S, ACK
    );

    modport slave (
        input  CYC, STB, WE, SEL, ADR, DAT_M,
        output DAT_S, ACK
    );

endinterface

// File: rtl/wishbone_arbiter_mux.sv
// Combinational steering of the granted master onto the shared slave port,
// with ACK gating so only the granted, still-cycling master sees an ACK.
module wishbone_mux
    import lc3b_types::*;
(
    input  lc3b_arb_sel i_sel,
    input  logic        i_valid,
    wishbone.slave      m0,
    wishbone.slave      m1,
    wishbone.master     s
);

    always_comb begin
        s.CYC   = 1'b0;
        s.STB   = 1'b0;
        s.WE    = 1'b0;
        s.SEL   = '0;
        s.ADR   = '0;
        s.DAT_M = '0;
        if (i_valid) begin
            if (i_sel == 1'b0) begin
                s.CYC   = m0.CYC;
                s.STB   = m0.STB;
                s.WE    = m0.WE;
                s.SEL   = m0.SEL;
                s.ADR   = m0.ADR;
                s.DAT_M = m0.DAT_M;
            end else begin
                s.CYC   = m1.CYC;
                s.STB   = m1.STB;
                s.WE    = m1.WE;
                s.SEL   = m1.SEL;
                s.ADR   = m1.ADR;
                s.DAT_M = m1.DAT_M;
            end
        end
    end

    // Read data is broadcast; each master qualifies it with its own ACK.
    assign m0.DAT_S = s.DAT_S;
    assign m1.DAT_S = s.DAT_S;

    assign m0.ACK = s.ACK & i_valid & ~i_sel & m0.CYC;
    assign m1.ACK = s.ACK & i_valid &  i_sel & m1.CYC;

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one wishbone slave between the I-side (m0) and
// D-side (m1) miss paths; one registered grant per complete transaction.
module wishbone_arbiter
    import lc3b_types::*;
(
    input  logic    clk,
    input  logic    rst_n,
    wishbone.slave  m0,
    wishbone.slave  m1,
    wishbone.master s
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_state_nxt;
    lc3b_arb_sel   r_last;
    lc3b_arb_sel   w_last_nxt;
    logic          w_req0;
    logic          w_req1;
    logic          w_valid;
    lc3b_arb_sel   w_sel;

    assign w_req0 = m0.CYC & m0.STB;
    assign w_req1 = m1.CYC & m1.STB;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // An abort (CYC dropped) takes priority over a coincident slave ACK.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if (w_req0 && (!w_req1 || r_last == 1'b1)) begin
                    w_state_nxt = ARB_BUSY0;
                    w_last_nxt  = 1'b0;
                end else if (w_req1) begin
                    w_state_nxt = ARB_BUSY1;
                    w_last_nxt  = 1'b1;
                end
            end
            ARB_BUSY0: begin
                if (!m0.CYC) begin
                    w_state_nxt = ARB_IDLE;
                end else if (s.ACK) begin
                    if (w_req1) begin
                        w_state_nxt = ARB_BUSY1;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            ARB_BUSY1: begin
                if (!m1.CYC) begin
                    w_state_nxt = ARB_IDLE;
                end else if (s.ACK) begin
                    if (w_req0) begin
                        w_state_nxt = ARB_BUSY0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign w_valid = (r_state == ARB_BUSY0) || (r_state == ARB_BUSY1);
    assign w_sel   = (r_state == ARB_BUSY1);

    wishbone_mux u_mux (
        .i_sel   (w_sel),
        .i_valid (w_valid),
        .m0      (m0),
        .m1      (m1),
        .s       (s)
    );

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: directed vector table, a saturated
// round-robin sequence and randomized traffic against a bus-ownership model.
module tb_wishbone_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wishbone m0_if ();
    wishbone m1_if ();
    wishbone s_if ();

    wishbone_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if.slave),
        .m1    (m1_if.slave),
        .s     (s_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DATA_K = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

    // Model: who owns the slave (-1 none) and who was granted last.
    int owner = -1;
    int last_g = 1;

    always @(posedge clk) begin
        if (!rst_n) begin
            owner  <= -1;
            last_g <= 1;
        end else if (owner < 0) begin
            if ((m0_if.CYC && m0_if.STB) && (m1_if.CYC && m1_if.STB)) begin
                owner  <= 1 - last_g;
                last_g <= 1 - last_g;
            end else if (m0_if.CYC && m0_if.STB) begin
                owner  <= 0;
                last_g <= 0;
            end else if (m1_if.CYC && m1_if.STB) begin
                owner  <= 1;
                last_g <= 1;
            end
        end else begin
            logic own_cyc;
            logic oth_req;
            own_cyc = (owner == 0) ? m0_if.CYC : m1_if.CYC;
            oth_req = (owner == 0) ? (m1_if.CYC && m1_if.STB) : (m0_if.CYC && m0_if.STB);
            if (!own_cyc) begin
                owner <= -1;
            end else if (s_if.ACK) begin
                if (oth_req) begin
                    owner  <= 1 - owner;
                    last_g <= 1 - owner;
                end else begin
                    owner <= -1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic          ecyc, estb, ewe, ea0, ea1;
        logic [15:0]   esel, eadr;
        logic [127:0]  edat;
        ecyc = 0; estb = 0; ewe = 0; esel = 0; eadr = 0; edat = 0;
        if (owner == 0) begin
            ecyc = m0_if.CYC; estb = m0_if.STB; ewe = m0_if.WE;
            esel = m0_if.SEL; eadr = m0_if.ADR; edat = m0_if.DAT_M;
        end else if (owner == 1) begin
            ecyc = m1_if.CYC; estb = m1_if.STB; ewe = m1_if.WE;
            esel = m1_if.SEL; eadr = m1_if.ADR; edat = m1_if.DAT_M;
        end
        ea0 = s_if.ACK && owner == 0 && m0_if.CYC;
        ea1 = s_if.ACK && owner == 1 && m1_if.CYC;
        chk("m_cyc", 128'(s_if.CYC), 128'(ecyc));
        chk("m_stb", 128'(s_if.STB), 128'(estb));
        chk("m_we", 128'(s_if.WE), 128'(ewe));
        chk("m_sel", 128'(s_if.SEL), 128'(esel));
        chk("m_adr", 128'(s_if.ADR), 128'(eadr));
        chk("m_datm", s_if.DAT_M, edat);
        chk("m_ack0", 128'(m0_if.ACK), 128'(ea0));
        chk("m_ack1", 128'(m1_if.ACK), 128'(ea1));
        chk("m_dats0", m0_if.DAT_S, s_if.DAT_S);
        chk("m_dats1", m1_if.DAT_S, s_if.DAT_S);
    endtask

    typedef struct {
        logic        rst;
        logic        c0, s0, c1, s1, ack;
        logic [15:0] adr0;
        logic        e_cyc, e_stb;
        logic [15:0] e_adr, e_sel;
        logic        e_a0, e_a1;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int grants[8];
        int ng;
        int cnt;
        int budget;

        // Directed per-cycle vectors; expected values are the state before the edge.
        vecs[0]  = '{1, 1,1,0,0, 0, 16'h0040, 0,0, 16'h0000, 16'h0000, 0,0}; // IDLE, m0 requests
        vecs[1]  = '{1, 1,1,0,0, 0, 16'h0040, 1,1, 16'h0040, 16'hFFFF, 0,0}; // 1-cycle latency
        vecs[2]  = '{1, 1,1,0,0, 1, 16'h0040, 1,1, 16'h0040, 16'hFFFF, 1,0}; // ACK passthrough
        vecs[3]  = '{1, 1,1,0,0, 0, 16'h0044, 0,0, 16'h0000, 16'h0000, 0,0}; // forced IDLE gap
        vecs[4]  = '{1, 1,1,1,1, 0, 16'h0044, 1,1, 16'h0044, 16'hFFFF, 0,0}; // re-grant new ADR
        vecs[5]  = '{1, 1,1,1,1, 1, 16'h0044, 1,1, 16'h0044, 16'hFFFF, 1,0}; // ACK, m1 waiting
        vecs[6]  = '{1, 1,1,1,1, 0, 16'h0044, 1,1, 16'h0200, 16'h0003, 0,0}; // handoff, no gap
        vecs[7]  = '{1, 1,1,0,0, 1, 16'h0044, 0,0, 16'h0200, 16'h0003, 0,0}; // m1 aborts, ACK dropped
        vecs[8]  = '{1, 1,1,0,0, 1, 16'h0044, 0,0, 16'h0000, 16'h0000, 0,0}; // IDLE ignores ACK
        vecs[9]  = '{1, 1,1,1,1, 0, 16'h0044, 1,1, 16'h0044, 16'hFFFF, 0,0};
        vecs[10] = '{0, 1,1,1,1, 1, 16'h0044, 1,1, 16'h0044, 16'hFFFF, 1,0}; // reset with ACK pending
        vecs[11] = '{1, 1,1,1,1, 1, 16'h0044, 0,0, 16'h0000, 16'h0000, 0,0}; // post-reset: all zero
        vecs[12] = '{1, 1,1,1,1, 0, 16'h0044, 1,1, 16'h0044, 16'hFFFF, 0,0}; // tie goes to m0
        vecs[13] = '{0, 1,1,1,1, 0, 16'h0044, 1,1, 16'h0044, 16'hFFFF, 0,0};
        vecs[14] = '{1, 0,0,0,0, 1, 16'h0044, 0,0, 16'h0000, 16'h0000, 0,0};

        m0_if.CYC = 0; m0_if.STB = 0; m0_if.WE = 0; m0_if.SEL = 16'hFFFF;
        m0_if.ADR = 16'h0040; m0_if.DAT_M = 128'h0;
        m1_if.CYC = 0; m1_if.STB = 0; m1_if.WE = 1; m1_if.SEL = 16'h0003;
        m1_if.ADR = 16'h0200; m1_if.DAT_M = 128'h1234;
        s_if.ACK = 0; s_if.DAT_S = DATA_K;
        rst_n = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst;
            m0_if.CYC = vecs[i].c0; m0_if.STB = vecs[i].s0;
            m1_if.CYC = vecs[i].c1; m1_if.STB = vecs[i].s1;
            s_if.ACK = vecs[i].ack;
            m0_if.ADR = vecs[i].adr0;
            #1;
            chk($sformatf("v%0d_cyc", i), 128'(s_if.CYC), 128'(vecs[i].e_cyc));
            chk($sformatf("v%0d_stb", i), 128'(s_if.STB), 128'(vecs[i].e_stb));
            chk($sformatf("v%0d_adr", i), 128'(s_if.ADR), 128'(vecs[i].e_adr));
            chk($sformatf("v%0d_sel", i), 128'(s_if.SEL), 128'(vecs[i].e_sel));
            chk($sformatf("v%0d_ack0", i), 128'(m0_if.ACK), 128'(vecs[i].e_a0));
            chk($sformatf("v%0d_ack1", i), 128'(m1_if.ACK), 128'(vecs[i].e_a1));
            chk($sformatf("v%0d_dat0", i), m0_if.DAT_S, DATA_K);
        end

        // Saturation: both always request, slave ACKs on the 3rd strobe cycle.
        @(negedge clk);
        rst_n = 0; s_if.ACK = 0;
        m0_if.ADR = 16'h0100; m1_if.ADR = 16'h0200;
        @(negedge clk);
        rst_n = 1;
        m0_if.CYC = 1; m0_if.STB = 1; m1_if.CYC = 1; m1_if.STB = 1;
        ng = 0; cnt = 0; budget = 0;
        while (ng < 8 && budget < 200) begin
            #1;
            s_if.ACK = 0;
            if (s_if.STB) begin
                cnt++;
                if (cnt == 3) begin
                    s_if.ACK = 1;
                    grants[ng] = (s_if.ADR == 16'h0200) ? 1 : 0;
                    ng++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            #1;
            check_model();
            budget++;
            @(negedge clk);
        end
        s_if.ACK = 0;
        chk("sat_count", 128'(ng), 128'(8));
        for (int k = 0; k < ng; k++)
            chk($sformatf("sat_grant%0d", k), 128'(grants[k]), 128'(k % 2));

        // Randomized traffic checked against the ownership model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 63) != 0);
            m0_if.CYC = ($urandom_range(0, 3) != 0);
            m0_if.STB = m0_if.CYC & ($urandom_range(0, 3) != 0);
            m0_if.WE = 1'($urandom);
            m0_if.SEL = 16'($urandom);
            m0_if.ADR = 16'($urandom);
            m0_if.DAT_M = {$urandom, $urandom, $urandom, $urandom};
            m1_if.CYC = ($urandom_range(0, 3) != 0);
            m1_if.STB = m1_if.CYC & ($urandom_range(0, 3) != 0);
            m1_if.WE = 1'($urandom);
            m1_if.SEL = 16'($urandom);
            m1_if.ADR = 16'($urandom);
            m1_if.DAT_M = {$urandom, $urandom, $urandom, $urandom};
            s_if.ACK = ($urandom_range(0, 2) == 0);
            s_if.DAT_S = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
